// File: rtl/lru_matrix_sets_pkg.sv
// Shared helpers for the multi-set matrix LRU: index-width helper and the
// response-kind encoding used when classifying responses.
package lru_pkg;

  function automatic int lru_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    RESP_HIT   = 2'd0,
    RESP_FILL  = 2'd1,
    RESP_EVICT = 2'd2,
    RESP_NONE  = 2'd3
  } resp_kind_e;

endpackage

// File: rtl/lru_matrix_sets_chk.sv
// Protocol checker: a hit must name a way that exists.
module lru_matrix_sets_chk #(
  parameter int WAYS  = 8,
  parameter int WAY_W = 3
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic             i_req_valid,
  input logic             i_req_hit,
  input logic [WAY_W-1:0] i_req_way
);
  a_hit_way_in_range: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_req_valid && i_req_hit) |-> ({1'b0, i_req_way} < (WAY_W + 1)'(WAYS)));
endmodule

// File: rtl/lru_matrix_sets_victim_select.sv
// Combinational victim choice for one set: lowest-index invalid eligible way
// first, otherwise the least-recent eligible way (ties to the lowest index).
module lru_victim_select #(
  parameter int WAYS  = 8,
  parameter int WAY_W = 3
) (
  input  logic [WAYS-1:0][WAYS-1:0] i_matrix,
  input  logic [WAYS-1:0]           i_valid,
  input  logic [WAYS-1:0]           i_lock,
  output logic [WAY_W-1:0]          o_way,
  output logic                      o_fill,
  output logic                      o_none
);
  logic [WAYS-1:0]  w_elig;
  logic [WAYS-1:0]  w_free;
  logic [WAYS-1:0]  w_lru;
  logic [WAY_W-1:0] w_free_idx;
  logic [WAY_W-1:0] w_lru_idx;
  logic [WAY_W-1:0] w_elig_idx;

  // A way is least recent in E when it is newer than no other eligible way.
  always_comb begin
    w_elig = ~i_lock;
    w_free = w_elig & ~i_valid;
    w_lru  = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_lru[i] = w_elig[i] && ((i_matrix[i] & w_elig & ~(WAYS'(1) << i)) == '0);
    end
  end

  // Downward scan leaves the lowest set index of each mask.
  always_comb begin
    w_free_idx = '0;
    w_lru_idx  = '0;
    w_elig_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      w_free_idx = w_free[i] ? WAY_W'(i) : w_free_idx;
      w_lru_idx  = w_lru[i]  ? WAY_W'(i) : w_lru_idx;
      w_elig_idx = w_elig[i] ? WAY_W'(i) : w_elig_idx;
    end
  end

  always_comb begin
    o_none = ~|w_elig;
    o_fill = |w_free;
    if (o_none) begin
      o_way = '0;
    end else if (o_fill) begin
      o_way = w_free_idx;
    end else if (|w_lru) begin
      o_way = w_lru_idx;
    end else begin
      o_way = w_elig_idx;
    end
  end

endmodule

// File: rtl/lru_matrix_sets.sv
// Multi-set square-matrix LRU: per-set recency matrix and valid vector,
// hit touch, miss victim selection with locking, and per-way invalidation.
module lru_matrix_sets
  import lru_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int SETS  = 16,
  parameter int WAY_W = lru_idx_w(WAYS),
  parameter int SET_W = lru_idx_w(SETS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  input  logic [SET_W-1:0] i_req_set,
  input  logic             i_req_hit,
  input  logic [WAY_W-1:0] i_req_way,
  input  logic [WAYS-1:0]  i_req_lock,
  input  logic             i_inv_valid,
  input  logic [SET_W-1:0] i_inv_set,
  input  logic [WAY_W-1:0] i_inv_way,
  output logic             o_inv_ready,
  output logic             o_resp_valid,
  output logic [WAY_W-1:0] o_resp_way,
  output logic             o_resp_fill,
  output logic             o_resp_none
);
  typedef logic [WAYS-1:0][WAYS-1:0] mat_t;

  mat_t             r_matrix [SETS];
  logic [WAYS-1:0]  r_valid  [SETS];
  logic             r_resp_valid;
  logic [WAY_W-1:0] r_resp_way;
  logic             r_resp_fill;
  logic             r_resp_none;

  logic [WAY_W-1:0] w_vic_way;
  logic             w_vic_fill;
  logic             w_vic_none;
  logic             w_req_way_ok;
  logic             w_inv_way_ok;

  // Most recent: row all ones except diagonal, column cleared.
  function automatic mat_t touch(input mat_t m, input logic [WAY_W-1:0] w);
    mat_t            r;
    logic [WAYS-1:0] oh;
    oh = WAYS'(1) << w;
    r  = m;
    for (int k = 0; k < WAYS; k++) begin
      r[k] = r[k] & ~oh;
    end
    r[w] = ~oh;
    return r;
  endfunction

  // Least recent: column set except diagonal, row cleared.
  function automatic mat_t demote(input mat_t m, input logic [WAY_W-1:0] w);
    mat_t            r;
    logic [WAYS-1:0] oh;
    oh = WAYS'(1) << w;
    r  = m;
    for (int k = 0; k < WAYS; k++) begin
      r[k] = r[k] | oh;
    end
    r[w] = '0;
    return r;
  endfunction

  assign w_req_way_ok = ({1'b0, i_req_way} < (WAY_W + 1)'(WAYS));
  assign w_inv_way_ok = ({1'b0, i_inv_way} < (WAY_W + 1)'(WAYS));
  assign o_inv_ready  = ~i_req_valid;

  lru_victim_select #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim_select (
    .i_matrix (r_matrix[i_req_set]),
    .i_valid  (r_valid[i_req_set]),
    .i_lock   (i_req_lock),
    .o_way    (w_vic_way),
    .o_fill   (w_vic_fill),
    .o_none   (w_vic_none)
  );

  lru_matrix_sets_chk #(.WAYS(WAYS), .WAY_W(WAY_W)) u_chk (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_hit   (i_req_hit),
    .i_req_way   (i_req_way)
  );

  // Requests take priority over invalidates; the update lands on this edge
  // so a back-to-back request to the same set sees it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_matrix[s] <= '0;
        r_valid[s]  <= '0;
      end
      r_resp_valid <= 1'b0;
      r_resp_way   <= '0;
      r_resp_fill  <= 1'b0;
      r_resp_none  <= 1'b0;
    end else begin
      r_resp_valid <= i_req_valid;
      if (i_req_valid) begin
        if (i_req_hit) begin
          if (w_req_way_ok) begin
            r_matrix[i_req_set] <= touch(r_matrix[i_req_set], i_req_way);
          end
          r_resp_way  <= i_req_way;
          r_resp_fill <= 1'b0;
          r_resp_none <= ~w_req_way_ok;
        end else begin
          if (!w_vic_none) begin
            r_matrix[i_req_set]           <= touch(r_matrix[i_req_set], w_vic_way);
            r_valid[i_req_set][w_vic_way] <= 1'b1;
          end
          r_resp_way  <= w_vic_way;
          r_resp_fill <= w_vic_fill & ~w_vic_none;
          r_resp_none <= w_vic_none;
        end
      end else if (i_inv_valid && w_inv_way_ok) begin
        r_valid[i_inv_set][i_inv_way] <= 1'b0;
        r_matrix[i_inv_set]           <= demote(r_matrix[i_inv_set], i_inv_way);
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_way   = r_resp_way;
  assign o_resp_fill  = r_resp_fill;
  assign o_resp_none  = r_resp_none;

endmodule
